// File: rtl/mant_multiplier.sv
// mant_multiplier: iterative shift-add significand multiplier; exact 2*MW-bit unsigned product for rounding.
// Latency: 11 cycles accept->out_valid (6 with `define MANT_MUL_RADIX4_EN, radix-4 with precomputed 3x multiple).
// Backpressure: one operation in flight; out_ready low holds DONE with product stable, in_ready low until handshake.
module mant_multiplier #(
    parameter int MW = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MW-1:0]     a,
    input  logic [MW-1:0]     b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*MW-1:0]   product
);

`ifdef MANT_MUL_RADIX4_EN
    localparam int MPW   = MW + (MW % 2);
    localparam int SH    = 2;
    localparam int STEPS = MPW / 2;
`else
    localparam int MPW   = MW;
    localparam int SH    = 1;
    localparam int STEPS = MW;
`endif
    localparam logic [3:0] LAST = 4'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [2*MW-1:0]   acc;
    logic [2*MW-1:0]   mcand;
    logic [2*MW-1:0]   addend;
    logic [MPW-1:0]    mplier;
    logic [3:0]        cnt;
    logic [2*MW-1:0]   a_ext;

    assign a_ext = {{MW{1'b0}}, a};

`ifdef MANT_MUL_RADIX4_EN
    logic [2*MW-1:0]   mcand3;

    // One recoded digit per step: 0, 1x, 2x or the precomputed 3x multiple.
    always_comb begin
        addend = '0;
        case (mplier[1:0])
            2'd1:    addend = mcand;
            2'd2:    addend = mcand << 1;
            2'd3:    addend = mcand3;
            default: addend = '0;
        endcase
    end
`else
    always_comb begin
        addend = '0;
        if (mplier[0]) addend = mcand;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`ifdef MANT_MUL_RADIX4_EN
            mcand3 <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc    <= '0;
                        mcand  <= a_ext;
                        mplier <= MPW'(b);
                        cnt    <= '0;
`ifdef MANT_MUL_RADIX4_EN
                        mcand3 <= a_ext + (a_ext << 1);
`endif
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Truncation is safe: the final product always fits in 2*MW bits.
                    acc    <= acc + addend;
                    mcand  <= mcand << SH;
                    mplier <= mplier >> SH;
                    cnt    <= cnt + 4'd1;
`ifdef MANT_MUL_RADIX4_EN
                    mcand3 <= mcand3 << SH;
`endif
                    if (cnt == LAST) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign product   = acc;

endmodule
